// File: rtl/operand_loader.sv
// Front-end input stage: synchronises and debounces the board buttons and mode switch,
// then commits each button chord into an operand load or a display-select change.
module operand_loader #(
    parameter int N             = 12,
    parameter int DB_CYCLES     = 50000,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] s,
    input  logic         b1,
    input  logic         b2,
    input  logic         b3,
    input  logic         pl,
    output logic [N-1:0] r1,
    output logic [N-1:0] r2,
    output logic [3:0]   r3,
    output logic [1:0]   dbcmd,
    output logic         load_pulse,
    output logic         err
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

    state_t          state, next_state;
    logic [3:0]      raw_meta, raw_sync, db;
    logic [N-1:0]    s_meta, s_sync;
    logic [CW-1:0]   db_cnt [4];
    logic [SW-1:0]   settle_cnt;
    logic            settle_clr, settle_inc;
    logic [2:0]      btn;
    logic            pl_db;
    logic [N-1:0]    r1_d, r2_d;
    logic [3:0]      r3_d;
    logic [1:0]      dbcmd_d;
    logic            err_d, pulse_d;

    // Bit order of the raw vector: {pl, b3, b2, b1}
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_meta <= '0;
            raw_sync <= '0;
            s_meta   <= '0;
            s_sync   <= '0;
        end else begin
            raw_meta <= {pl, b3, b2, b1};
            raw_sync <= raw_meta;
            s_meta   <= s;
            s_sync   <= s_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (raw_sync[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn   = db[2:0];
    assign pl_db = db[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            r1         <= '0;
            r2         <= '0;
            r3         <= '0;
            dbcmd      <= '0;
            err        <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            if (settle_clr)      settle_cnt <= '0;
            else if (settle_inc) settle_cnt <= settle_cnt + 1'b1;
            r1         <= r1_d;
            r2         <= r2_d;
            r3         <= r3_d;
            dbcmd      <= dbcmd_d;
            err        <= err_d;
            load_pulse <= pulse_d;
        end
    end

    always_comb begin
        next_state = state;
        settle_clr = 1'b0;
        settle_inc = 1'b0;
        r1_d       = r1;
        r2_d       = r2;
        r3_d       = r3;
        dbcmd_d    = dbcmd;
        err_d      = err;
        pulse_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn != 3'b000) begin
                    next_state = SETTLE;
                    settle_clr = 1'b1;
                end
            end
            SETTLE: begin
                if (btn == 3'b000)                next_state = IDLE;
                else if (settle_cnt == SETTLE_LAST) next_state = COMMIT;
                else                              settle_inc = 1'b1;
            end
            COMMIT: begin
                next_state = HOLD;
                // Any chord other than a single button is rejected without touching registers
                if (btn == 3'b001 || btn == 3'b010 || btn == 3'b100) begin
                    err_d = 1'b0;
                    if (pl_db) begin
                        dbcmd_d = 2'b00;
                        pulse_d = 1'b1;
                        if (btn == 3'b001)      r1_d = s_sync;
                        else if (btn == 3'b010) r2_d = s_sync;
                        else                    r3_d = s_sync[3:0];
                    end else begin
                        if (btn == 3'b001)      dbcmd_d = 2'b01;
                        else if (btn == 3'b010) dbcmd_d = 2'b10;
                        else                    dbcmd_d = 2'b11;
                    end
                end else begin
                    err_d   = 1'b1;
                    dbcmd_d = 2'b00;
                end
            end
            HOLD: begin
                if (btn == 3'b000) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
